// File: rtl/branch_exec_q.sv
// Branch execution core with a resolution FIFO toward the frontend.
// Optional compressed-ISA support via `LEN5_C_EN (pc+2 links, no misaligned-target exception).
package expipe_pkg;
   typedef enum logic [3:0] {
      BU_BEQ, BU_BNE, BU_BLT, BU_BGE, BU_BLTU, BU_BGEU,
      BU_JAL, BU_JALR, BU_CALL, BU_RET
   } branch_ctl_t;
endpackage

package fetch_pkg;
   localparam int unsigned XLEN = 64;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
      logic            taken;
      logic            mispredict;
   } resolution_t;
endpackage

module branch_exec_q #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned ROB_IDX_W = 4,
   parameter int unsigned RES_DEPTH = 4,
   parameter int unsigned WB_SKIP   = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      rs_valid_i,
   output logic                      rs_ready_o,
   input  expipe_pkg::branch_ctl_t   rs_type_i,
   input  logic [XLEN-1:0]           rs_rs1_i,
   input  logic [XLEN-1:0]           rs_rs2_i,
   input  logic [XLEN-1:0]           rs_imm_i,
   input  logic [XLEN-1:0]           rs_pc_i,
   input  logic [XLEN-1:0]           rs_pred_target_i,
   input  logic                      rs_pred_taken_i,
   input  logic [ROB_IDX_W-1:0]      rs_rob_idx_i,
   input  logic                      rs_compressed_i,
   output logic                      wb_valid_o,
   input  logic                      wb_ready_i,
   output logic [ROB_IDX_W-1:0]      wb_rob_idx_o,
   output logic [XLEN-1:0]           wb_link_addr_o,
   output logic                      wb_mis_o,
   output logic                      wb_except_o,
   output logic                      fe_valid_o,
   input  logic                      fe_ready_i,
   output fetch_pkg::resolution_t    fe_res_o,
   output logic                      fe_call_o,
   output logic                      fe_ret_o,
   output logic [XLEN-1:0]           fe_link_addr_o,
   output logic                      mis_pending_o
);
   import expipe_pkg::*;

   localparam int unsigned PW = $clog2(RES_DEPTH);

   // Handshakes: a transfer happens on a cycle where valid & ready are both high;
   // valid never waits on ready, and payload is held stable while valid & !ready.

   logic            taken, mis, except_c, accept, pop, full, empty, wb_busy, mis_pending_q;
   logic [XLEN-1:0] target, link, pc_sum, reg_sum;

   assign pc_sum  = rs_pc_i + rs_imm_i;
   assign reg_sum = rs_rs1_i + rs_imm_i;

   always_comb begin
      taken  = 1'b0;
      target = pc_sum;
      case (rs_type_i)
         BU_BEQ:           taken = (rs_rs1_i == rs_rs2_i);
         BU_BNE:           taken = (rs_rs1_i != rs_rs2_i);
         BU_BLT:           taken = ($signed(rs_rs1_i) <  $signed(rs_rs2_i));
         BU_BGE:           taken = ($signed(rs_rs1_i) >= $signed(rs_rs2_i));
         BU_BLTU:          taken = (rs_rs1_i <  rs_rs2_i);
         BU_BGEU:          taken = (rs_rs1_i >= rs_rs2_i);
         BU_JAL, BU_CALL:  taken = 1'b1;
         BU_JALR, BU_RET: begin
            taken  = 1'b1;
            target = {reg_sum[XLEN-1:1], 1'b0};
         end
         default:          taken = 1'b0;
      endcase
   end

`ifdef LEN5_C_EN
   assign link     = rs_pc_i + (rs_compressed_i ? XLEN'(2) : XLEN'(4));
   assign except_c = 1'b0;
`else
   logic unused_compressed;
   assign unused_compressed = rs_compressed_i;
   assign link     = rs_pc_i + XLEN'(4);
   assign except_c = taken & target[1];
`endif

   assign mis = (rs_pred_taken_i != taken) | (rs_pred_taken_i & (rs_pred_target_i != target));

   assign rs_ready_o = !mis_pending_q & !full & !wb_busy & !flush_i;
   assign accept     = rs_valid_i & rs_ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 mis_pending_q <= 1'b0;
      else if (flush_i)            mis_pending_q <= 1'b0;
      else if (accept & mis)       mis_pending_q <= 1'b1;
   end
   assign mis_pending_o = mis_pending_q;

   generate
      if (WB_SKIP == 0) begin : g_wb_reg
         logic                 valid_q, mis_q, except_q;
         logic [ROB_IDX_W-1:0] rob_q;
         logic [XLEN-1:0]      link_q;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               valid_q  <= 1'b0;
               mis_q    <= 1'b0;
               except_q <= 1'b0;
               rob_q    <= '0;
               link_q   <= '0;
            end else if (flush_i) begin
               valid_q  <= 1'b0;
            end else if (accept) begin
               valid_q  <= 1'b1;
               mis_q    <= mis;
               except_q <= except_c;
               rob_q    <= rs_rob_idx_i;
               link_q   <= link;
            end else if (wb_ready_i) begin
               valid_q  <= 1'b0;
            end
         end
         assign wb_busy        = valid_q & !wb_ready_i;
         assign wb_valid_o     = valid_q;
         assign wb_rob_idx_o   = rob_q;
         assign wb_link_addr_o = link_q;
         assign wb_mis_o       = mis_q;
         assign wb_except_o    = except_q;
      end else begin : g_wb_skip
         logic unused_wb_ready;
         assign unused_wb_ready = wb_ready_i;
         assign wb_busy         = 1'b0;
         assign wb_valid_o      = accept;
         assign wb_rob_idx_o    = rs_rob_idx_i;
         assign wb_link_addr_o  = link;
         assign wb_mis_o        = mis;
         assign wb_except_o     = except_c;
      end
   endgenerate

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [PW:0]           wr_q, rd_q;
   logic [XLEN-1:0]       pc_mem [RES_DEPTH];
   logic [XLEN-1:0]       tgt_mem [RES_DEPTH];
   logic [XLEN-1:0]       link_mem [RES_DEPTH];
   logic [RES_DEPTH-1:0]  taken_mem, mis_mem, call_mem, ret_mem;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[PW-1:0] == rd_q[PW-1:0]) & (wr_q[PW] != rd_q[PW]);
   assign pop   = !empty & fe_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q      <= '0;
         rd_q      <= '0;
         taken_mem <= '0;
         mis_mem   <= '0;
         call_mem  <= '0;
         ret_mem   <= '0;
         for (int i = 0; i < RES_DEPTH; i++) begin
            pc_mem[i]   <= '0;
            tgt_mem[i]  <= '0;
            link_mem[i] <= '0;
         end
      end else if (flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (accept) begin
            pc_mem[wr_q[PW-1:0]]    <= rs_pc_i;
            tgt_mem[wr_q[PW-1:0]]   <= target;
            link_mem[wr_q[PW-1:0]]  <= link;
            taken_mem[wr_q[PW-1:0]] <= taken;
            mis_mem[wr_q[PW-1:0]]   <= mis;
            call_mem[wr_q[PW-1:0]]  <= (rs_type_i == BU_CALL);
            ret_mem[wr_q[PW-1:0]]   <= (rs_type_i == BU_RET);
            wr_q                    <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
      end
   end

   assign fe_valid_o          = !empty;
   assign fe_res_o.pc         = pc_mem[rd_q[PW-1:0]];
   assign fe_res_o.target     = tgt_mem[rd_q[PW-1:0]];
   assign fe_res_o.taken      = taken_mem[rd_q[PW-1:0]];
   assign fe_res_o.mispredict = mis_mem[rd_q[PW-1:0]];
   assign fe_call_o           = call_mem[rd_q[PW-1:0]];
   assign fe_ret_o            = ret_mem[rd_q[PW-1:0]];
   assign fe_link_addr_o      = link_mem[rd_q[PW-1:0]];
endmodule
